// File: rtl/io_seq_checker_if.sv
// Bundle of configuration, stimulus and status signals for io_seq_checker.
// The checker sits on the slave side; whoever programs and starts it is master.
interface io_seq_checker_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int TO_W  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] io_in;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic [AW:0]      seq_len;
    logic [WIDTH-1:0] mask;
    logic             strict;
    logic [TO_W-1:0]  timeout;
    logic             start;
    logic             abort;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [AW:0]      idx;

    modport master (
        output io_in, cfg_we, cfg_addr, cfg_data, seq_len, mask, strict,
               timeout, start, abort,
        input  busy, pass, fail, fail_code, idx
    );

    modport slave (
        input  io_in, cfg_we, cfg_addr, cfg_data, seq_len, mask, strict,
               timeout, start, abort,
        output busy, pass, fail, fail_code, idx
    );
endinterface

// File: rtl/io_seq_checker.sv
// Pad-bus sequence checker: watches a synchronized copy of io_in and walks
// through a programmable table of expected values, one entry per cycle at most.
// Reports pass, a per-entry idle timeout, or a strict-mode glitch to a wrong value.
module io_seq_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int TO_W  = 16
) (
    input logic         wb_clk_i,
    input logic         wb_rst_i,
    io_seq_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_mem [DEPTH];
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s2_prev;
    logic [TO_W-1:0]  timer;
    logic             busy_r;
    logic             pass_r;
    logic             fail_r;
    logic [1:0]       code_r;
    logic [AW:0]      idx_r;

    logic [WIDTH-1:0] exp_cur;
    logic [WIDTH-1:0] s2_masked;
    logic [WIDTH-1:0] prev_masked;
    logic             is_match;
    logic             is_strict_err;
    logic             is_timeout;
    logic [AW:0]      idx_inc;

    assign exp_cur       = exp_mem[idx_r[AW-1:0]];
    assign s2_masked     = s2 & bus.mask;
    assign prev_masked   = s2_prev & bus.mask;
    assign is_match      = (s2_masked == (exp_cur & bus.mask));
    assign is_strict_err = bus.strict && (idx_r != '0) &&
                           (s2_masked != prev_masked) && !is_match;
    assign is_timeout    = (bus.timeout != '0) &&
                           (timer == (bus.timeout - TO_W'(1)));
    assign idx_inc       = idx_r + (AW+1)'(1);

    assign bus.busy      = busy_r;
    assign bus.pass      = pass_r;
    assign bus.fail      = fail_r;
    assign bus.fail_code = code_r;
    assign bus.idx       = idx_r;

    // Two-flop synchronizer for the asynchronous pad bus, plus a one-cycle history for strict mode
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1      <= '0;
            s2      <= '0;
            s2_prev <= '0;
        end else begin
            s1      <= bus.io_in;
            s2      <= s1;
            s2_prev <= s2;
        end
    end

    // Expected-value table; survives reset and is write-protected while a run is active
    always_ff @(posedge wb_clk_i) begin
        if (bus.cfg_we && !busy_r) begin
            exp_mem[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Run control: abort beats start, and within a run match beats strict error beats timeout
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            pass_r <= 1'b0;
            fail_r <= 1'b0;
            code_r <= 2'b00;
            idx_r  <= '0;
            timer  <= '0;
        end else if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            pass_r <= 1'b0;
            fail_r <= 1'b0;
            code_r <= 2'b00;
            idx_r  <= '0;
            timer  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (is_match) begin
                        idx_r <= idx_inc;
                        timer <= '0;
                        if (idx_inc == bus.seq_len) begin
                            state  <= PASS;
                            busy_r <= 1'b0;
                            pass_r <= 1'b1;
                        end
                    end else if (is_strict_err) begin
                        state  <= FAIL;
                        busy_r <= 1'b0;
                        fail_r <= 1'b1;
                        code_r <= 2'b10;
                    end else begin
                        timer <= timer + TO_W'(1);
                        if (is_timeout) begin
                            state  <= FAIL;
                            busy_r <= 1'b0;
                            fail_r <= 1'b1;
                            code_r <= 2'b01;
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        fail_r <= 1'b0;
                        code_r <= 2'b00;
                        idx_r  <= '0;
                        timer  <= '0;
                        if (bus.seq_len != '0) begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                            pass_r <= 1'b0;
                        end else begin
                            state  <= PASS;
                            busy_r <= 1'b0;
                            pass_r <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
